// File: rtl/pard_ctrl_axi_slave_pkg.sv
// rtl/pard_ctrl_axi_slave_pkg.sv - register offsets, CTRL fields, AXI codes and FSM states
package pard_ctrl_axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [2:0] SIZE_64     = 3'b011;

    // Offsets are 64-bit word indices, i.e. addr[11:3]
    localparam logic [8:0] OFF_CTRL       = 9'd0;
    localparam logic [8:0] OFF_SCRATCH    = 9'd1;
    localparam logic [8:0] OFF_CYCLE      = 9'd2;
    localparam logic [8:0] OFF_IRQ_STATUS = 9'd3;
    localparam logic [8:0] OFF_IRQ_MASK   = 9'd4;

    localparam int          CTRL_NOHYPE_LSB    = 0;
    localparam int          CTRL_CORE_RSTN_LSB = 8;
    localparam logic [63:0] CTRL_MASK          = 64'h0000_0000_0000_0307;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

    function automatic logic [63:0] strb_expand(input logic [7:0] strb);
        logic [63:0] bits;
        for (int i = 0; i < 8; i++) bits[i*8 +: 8] = {8{strb[i]}};
        return bits;
    endfunction

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [63:0] bits);
        return (old_v & ~bits) | (new_v & bits);
    endfunction

endpackage

// File: rtl/pard_ctrl_regfile.sv
// rtl/pard_ctrl_regfile.sv - register storage, byte-strobe merge, IRQ latch and cycle counter
// CYCLE counter present only when PARD_CTRL_CYCLE_CNT_EN is defined.
module pard_ctrl_regfile
    import pard_ctrl_axi_slave_pkg::*;
#(
    parameter int NINTR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NINTR-1:0] i_intrs,
    input  logic             i_wr_en,
    input  logic [8:0]       i_wr_off,
    input  logic [63:0]      i_wr_data,
    input  logic [7:0]       i_wr_strb,
    input  logic [8:0]       i_rd_off,
    output logic [63:0]      o_rd_data,
    output logic [2:0]       o_nohype,
    output logic [1:0]       o_core_rstn,
    output logic             o_irq
);
    localparam logic [63:0] IRQ_BITS = (64'd1 << NINTR) - 64'd1;

    logic [63:0] r_ctrl;
    logic [63:0] r_scratch;
    logic [63:0] r_irq_status;
    logic [63:0] r_irq_mask;
    logic        r_irq;
    logic [63:0] w_strb_bits;
    logic [63:0] w_clr;
    logic [63:0] w_cycle;

    assign w_strb_bits = strb_expand(i_wr_strb);

    always_comb begin
        w_clr = '0;
        if (i_wr_en && i_wr_off == OFF_IRQ_STATUS) w_clr = i_wr_data & w_strb_bits & IRQ_BITS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl       <= '0;
            r_scratch    <= '0;
            r_irq_status <= '0;
            r_irq_mask   <= '0;
            r_irq        <= 1'b0;
        end else begin
            if (i_wr_en && i_wr_off == OFF_CTRL)
                r_ctrl <= strb_merge(r_ctrl, i_wr_data, w_strb_bits) & CTRL_MASK;
            if (i_wr_en && i_wr_off == OFF_SCRATCH)
                r_scratch <= strb_merge(r_scratch, i_wr_data, w_strb_bits);
            if (i_wr_en && i_wr_off == OFF_IRQ_MASK)
                r_irq_mask <= strb_merge(r_irq_mask, i_wr_data, w_strb_bits) & IRQ_BITS;
            // A new interrupt level wins over a W1C of the same bit
            r_irq_status <= (r_irq_status & ~w_clr) | {{(64-NINTR){1'b0}}, i_intrs};
            r_irq        <= |(r_irq_status & r_irq_mask);
        end
    end

`ifdef PARD_CTRL_CYCLE_CNT_EN
    logic [63:0] r_cycle;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cycle <= '0;
        else        r_cycle <= r_cycle + 64'd1;
    end
    assign w_cycle = r_cycle;
`else
    assign w_cycle = '0;
`endif

    always_comb begin
        o_rd_data = '0;
        case (i_rd_off)
            OFF_CTRL:       o_rd_data = r_ctrl;
            OFF_SCRATCH:    o_rd_data = r_scratch;
            OFF_CYCLE:      o_rd_data = w_cycle;
            OFF_IRQ_STATUS: o_rd_data = r_irq_status;
            OFF_IRQ_MASK:   o_rd_data = r_irq_mask;
            default:        o_rd_data = '0;
        endcase
    end

    assign o_nohype    = r_ctrl[CTRL_NOHYPE_LSB +: 3];
    assign o_core_rstn = r_ctrl[CTRL_CORE_RSTN_LSB +: 2];
    assign o_irq       = r_irq;

endmodule

// File: rtl/pard_ctrl_axi_slave.sv
// rtl/pard_ctrl_axi_slave.sv - AXI4 MMIO responder for the PARD control/status register bank
// Optional CYCLE counter: PARD_CTRL_CYCLE_CNT_EN.
module pard_ctrl_axi_slave
    import pard_ctrl_axi_slave_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int NINTR  = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [63:0]       s_axi_wdata,
    input  logic [7:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [63:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [NINTR-1:0]  intrs,
    output logic [2:0]        nohype_settings,
    output logic [1:0]        core_rstn,
    output logic              irq
);
    wr_state_e       r_wstate, w_wstate_nxt;
    rd_state_e       r_rstate, w_rstate_nxt;
    logic            r_out_en;
    logic [ID_W-1:0] r_wid, r_rid;
    logic [8:0]      r_waddr, r_raddr, w_raddr_nxt, w_rd_off;
    logic [7:0]      r_wlen, r_wcnt, r_rlen, r_rcnt;
    logic            r_wfixed, r_wsize_err, r_werr, r_rfixed, r_rsize_err;
    logic [1:0]      r_bresp;
    logic [63:0]     r_rdata, w_rd_data;
    logic            w_aw_hs, w_w_hs, w_ar_hs, w_r_hs, w_wlast_beat, w_rlast_beat, w_ar_size_err;
    logic            w_unused;

    assign w_unused = ^{s_axi_awaddr[ADDR_W-1:12], s_axi_awaddr[2:0],
                        s_axi_araddr[ADDR_W-1:12], s_axi_araddr[2:0]};

    assign s_axi_awready = r_out_en && (r_wstate == W_IDLE);
    assign s_axi_wready  = (r_wstate == W_DATA);
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bid     = r_wid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_out_en && (r_rstate == R_IDLE);
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rlast   = s_axi_rvalid && w_rlast_beat;
    assign s_axi_rresp   = (s_axi_rvalid && r_rsize_err) ? RESP_SLVERR : RESP_OKAY;

    assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
    assign w_w_hs        = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_r_hs        = s_axi_rvalid && s_axi_rready;
    assign w_wlast_beat  = (r_wcnt == r_wlen);
    assign w_rlast_beat  = (r_rcnt == r_rlen);
    assign w_ar_size_err = (s_axi_arsize != SIZE_64);
    // WRAP bursts advance like INCR; only FIXED holds the address
    assign w_raddr_nxt   = r_rfixed ? r_raddr : r_raddr + 9'd1;
    assign w_rd_off      = (r_rstate == R_IDLE) ? s_axi_araddr[11:3] : w_raddr_nxt;

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
            W_RESP:  if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_rlast_beat) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_en    <= 1'b0;
            r_wstate    <= W_IDLE;
            r_rstate    <= R_IDLE;
            r_wid       <= '0;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wfixed    <= 1'b0;
            r_wsize_err <= 1'b0;
            r_werr      <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_rid       <= '0;
            r_raddr     <= '0;
            r_rlen      <= '0;
            r_rcnt      <= '0;
            r_rfixed    <= 1'b0;
            r_rsize_err <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_out_en <= 1'b1;
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            if (w_aw_hs) begin
                r_wid       <= s_axi_awid;
                r_waddr     <= s_axi_awaddr[11:3];
                r_wlen      <= s_axi_awlen;
                r_wcnt      <= '0;
                r_wfixed    <= (s_axi_awburst == BURST_FIXED);
                r_wsize_err <= (s_axi_awsize != SIZE_64);
                r_werr      <= 1'b0;
            end
            if (w_w_hs) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (!r_wfixed) r_waddr <= r_waddr + 9'd1;
                if (s_axi_wlast != w_wlast_beat) r_werr <= 1'b1;
                if (w_wlast_beat)
                    r_bresp <= (r_wsize_err || r_werr || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_ar_hs) begin
                r_rid       <= s_axi_arid;
                r_raddr     <= s_axi_araddr[11:3];
                r_rlen      <= s_axi_arlen;
                r_rcnt      <= '0;
                r_rfixed    <= (s_axi_arburst == BURST_FIXED);
                r_rsize_err <= w_ar_size_err;
                r_rdata     <= w_ar_size_err ? 64'd0 : w_rd_data;
            end else if (w_r_hs && !w_rlast_beat) begin
                r_raddr <= w_raddr_nxt;
                r_rcnt  <= r_rcnt + 8'd1;
                r_rdata <= r_rsize_err ? 64'd0 : w_rd_data;
            end
        end
    end

    pard_ctrl_regfile #(.NINTR(NINTR)) u_regfile (
        .clk         (aclk),
        .rst_n       (aresetn),
        .i_intrs     (intrs),
        .i_wr_en     (w_w_hs && !r_wsize_err),
        .i_wr_off    (r_waddr),
        .i_wr_data   (s_axi_wdata),
        .i_wr_strb   (s_axi_wstrb),
        .i_rd_off    (w_rd_off),
        .o_rd_data   (w_rd_data),
        .o_nohype    (nohype_settings),
        .o_core_rstn (core_rstn),
        .o_irq       (irq)
    );

endmodule
